lsu_rmw: RTL and testbench

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_rmw.sv | 131 +++++++++++++
 tb/tb_lsu_rmw.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-wide memory: byte/halfword/word access with
// read-modify-write for sub-word stores and sign/zero extension on loads.
module lsu_rmw (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dm_WE,
  output logic [31:0] dm_WD,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_RD
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_sext;
  logic [31:0] r_rdata;
  logic [31:0] r_wd;
  logic        r_done;
  logic        r_err;

  logic        w_mis;
  logic        w_need_rd;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  always_comb begin
    w_mis = (size == 2'b11) ||
            (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00);
    // Only a word store can skip the read; sub-word stores merge into the old word.
    w_need_rd = !we || (size != 2'b10);
  end

  always_comb begin
    w_byte  = dm_RD[{r_addr[1:0], 3'b000} +: 8];
    w_half  = dm_RD[{r_addr[1], 4'b0000} +: 16];
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sext & w_half[15]}}, w_half};
      default: w_load = dm_RD;
    endcase
    w_merge = dm_RD;
    if (r_size == 2'b00)
      w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_rdata <= '0;
      r_wd    <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_addr  <= addr;
            r_wdata <= wdata[15:0];
            r_size  <= size;
            r_we    <= we;
            r_sext  <= sext;
            if (w_mis) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (w_need_rd) begin
              r_state <= RD;
            end else begin
              r_state <= WR;
              r_wd    <= wdata;
            end
          end
        end
        RD: begin
          if (r_we) begin
            r_state <= WR;
            r_wd    <= w_merge;
          end else begin
            r_state <= DONE;
            r_rdata <= w_load;
            r_done  <= 1'b1;
          end
        end
        WR: begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_wd    <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = (r_state == RD) || (r_state == WR);
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign dm_WE   = (r_state == WR) && reset;
  assign dm_WD   = r_wd;
  assign dm_addr = {r_addr[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a 1024-word memory model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        reset, req, we, sext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, dm_WE;
  logic [31:0] rdata, dm_WD, dm_addr, dm_RD;

  logic [31:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  int unsigned n_asrt = 0;
  int unsigned n_fail = 0;
  int unsigned we_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned we_base, done_base;

  lsu_rmw dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .dm_WE(dm_WE), .dm_WD(dm_WD), .dm_addr(dm_addr), .dm_RD(dm_RD)
  );

  always #5 clk = ~clk;

  assign dm_RD = mem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (dm_WE) mem[dm_addr[11:2]] <= dm_WD;
    if (dm_WE) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    step();
    pre_we  = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = d;
    step();
    req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = '0; wdata = '0;
    step();
    poke(10'd1, 32'h11223344);
    step();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wd", dm_WD, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_we", {31'd0, dm_WE}, 32'd0);
    reset = 1'b1;
    step();

    // word load of the preloaded word
    issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("wl_busy", {31'd0, busy}, 32'd1);
    chk("wl_addr", dm_addr, 32'h4);
    chk("wl_done_c1", {31'd0, done}, 32'd0);
    step();
    chk("wl_done_c2", {31'd0, done}, 32'd1);
    chk("wl_rdata", rdata, 32'h11223344);
    step();
    chk("wl_idle_done", {31'd0, done}, 32'd0);

    // word store
    we_base = we_cnt;
    issue(1'b1, 2'b10, 1'b0, 32'h4, 32'h000000C8);
    chk("ws_we", {31'd0, dm_WE}, 32'd1);
    chk("ws_wd", dm_WD, 32'h000000C8);
    chk("ws_addr", dm_addr, 32'h4);
    chk("ws_done_c1", {31'd0, done}, 32'd0);
    step();
    chk("ws_done_c2", {31'd0, done}, 32'd1);
    chk("ws_err", {31'd0, err}, 32'd0);
    chk("ws_we_off", {31'd0, dm_WE}, 32'd0);
    chk("ws_mem", mem[1], 32'h000000C8);
    chk("ws_we_cnt", we_cnt - we_base, 32'd1);
    step();
    chk("ws_idle_wd", dm_WD, 32'd0);
    chk("ws_idle_addr", dm_addr, 32'h4);

    // byte store read-modify-write
    poke(10'd3, 32'hDDCCBBAA);
    issue(1'b1, 2'b00, 1'b0, 32'h0000000D, 32'h000000AB);
    chk("bs_rd_busy", {31'd0, busy}, 32'd1);
    chk("bs_rd_we", {31'd0, dm_WE}, 32'd0);
    chk("bs_addr", dm_addr, 32'hC);
    step();
    chk("bs_wr_we", {31'd0, dm_WE}, 32'd1);
    chk("bs_wr_wd", dm_WD, 32'hDDCCABAA);
    chk("bs_done_c2", {31'd0, done}, 32'd0);
    step();
    chk("bs_done_c3", {31'd0, done}, 32'd1);
    chk("bs_mem", mem[3], 32'hDDCCABAA);
    step();

    // halfword / byte loads with extension
    poke(10'd1, 32'h8001FFFF);
    issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
    step();
    chk("hl_s_done", {31'd0, done}, 32'd1);
    chk("hl_s_rdata", rdata, 32'hFFFF8001);
    step();
    issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
    step();
    chk("hl_z_rdata", rdata, 32'h00008001);
    step();
    issue(1'b0, 2'b00, 1'b0, 32'h4, 32'h0);
    step();
    chk("bl_z_rdata", rdata, 32'h000000FF);
    step();
    issue(1'b0, 2'b00, 1'b1, 32'h5, 32'h0);
    step();
    chk("bl_s_rdata", rdata, 32'hFFFFFFFF);
    step();

    // misaligned word load, then illegal-size store
    we_base = we_cnt;
    issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    chk("mis_done", {31'd0, done}, 32'd1);
    chk("mis_err", {31'd0, err}, 32'd1);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    chk("mis_rdata", rdata, 32'hFFFFFFFF);
    step();
    chk("mis_done_off", {31'd0, done}, 32'd0);
    issue(1'b1, 2'b11, 1'b0, 32'h0, 32'h12345678);
    chk("ill_err", {31'd0, err}, 32'd1);
    step();
    step();
    chk("err_no_write", we_cnt - we_base, 32'd0);

    // reset asserted during WR of a halfword store
    poke(10'd2, 32'h55667788);
    done_base = done_cnt;
    issue(1'b1, 2'b01, 1'b0, 32'hA, 32'h00001234);
    step();
    chk("rw_in_wr", {31'd0, dm_WE}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rw_we_gated", {31'd0, dm_WE}, 32'd0);
    step();
    chk("rw_mem", mem[2], 32'h55667788);
    chk("rw_busy", {31'd0, busy}, 32'd0);
    chk("rw_rdata", rdata, 32'd0);
    reset = 1'b1;
    step();
    step();
    chk("rw_no_done", done_cnt - done_base, 32'd0);
    chk("rw_idle_wd", dm_WD, 32'd0);

    // back-to-back requests held high
    done_base = done_cnt;
    req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h4;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("b2b_done_%0d", k), {31'd0, done}, (k % 3 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_busy_%0d", k), {31'd0, busy}, (k % 3 == 0) ? 32'd1 : 32'd0);
    end
    req = 1'b0;
    step();
    chk("b2b_done_cnt", done_cnt - done_base, 32'd3);

    // req held through reset release
    reset = 1'b0;
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h4;
    step();
    step();
    chk("rr_busy_in_rst", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    step();
    req = 1'b0;
    chk("rr_accept", {31'd0, busy}, 32'd1);
    step();
    chk("rr_done", {31'd0, done}, 32'd1);
    chk("rr_rdata", rdata, 32'h8001FFFF);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
